sr_flag_arbiter: RTL and testbench

//  Shares a bank of synchronous SR flag cells among several requesters.

---
 rtl/sr_flag_arbiter_pkg.sv | 18 +
 rtl/sr_flag_cell.sv | 23 ++
 rtl/sr_flag_arbiter.sv | 107 ++++++++++
 tb/tb_sr_flag_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_arbiter_pkg.sv
// rtl/sr_flag_arbiter_pkg.sv - shared op encodings and request legality helper for the SR flag arbiter
package sr_flag_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_ILL = 2'b11
  } sr_op_e;

  localparam int IDW = 3;

  // A request is legal only with a defined op and a flag index inside the bank.
  function automatic logic op_legal(input logic [1:0] op, input int flag, input int n_flags);
    return (op != OP_ILL) && (flag < n_flags);
  endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// rtl/sr_flag_cell.sv - single synchronous SR flag cell with async clear
module sr_flag_cell (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      if (s) begin
        q <= 1'b1;
      end else if (r) begin
        q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter sharing a bank of SR flag cells among requesters
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_FLAGS = 8,
  parameter int FW      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [FW*N_REQ-1:0]   req_flag,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_FLAGS-1:0]    flags,
  output logic [IDW-1:0]        gnt_id,
  output logic                  err,
  output logic [IDW-1:0]        err_id
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic            any_valid;
  logic            grant;
  logic [1:0]      win_op;
  logic [FW-1:0]   win_flag;
  logic            legal;
  logic [IDW-1:0]  ptr_next;
  logic [N_FLAGS-1:0] cell_en;
  logic            cell_s;
  logic            cell_r;

  // First valid requester at or after the pointer, wrapping around the requester ring.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  assign grant = en && !reset && any_valid;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant && (winner == IDW'(i));
    end
  end

  always_comb begin
    win_op   = '0;
    win_flag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        win_op   = req_op[2*i +: 2];
        win_flag = req_flag[FW*i +: FW];
      end
    end
  end

  assign legal    = op_legal(win_op, int'(win_flag), N_FLAGS);
  assign ptr_next = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      gnt_id <= '0;
      err    <= 1'b0;
      err_id <= '0;
    end else begin
      err <= 1'b0;
      if (grant) begin
        ptr    <= ptr_next;
        gnt_id <= winner;
        if (!legal) begin
          err    <= 1'b1;
          err_id <= winner;
        end
      end
    end
  end

  // Set/clear are broadcast; only the addressed cell is enabled, and illegal grants enable none.
  assign cell_s = (win_op == OP_SET);
  assign cell_r = (win_op == OP_CLR);

  for (genvar j = 0; j < N_FLAGS; j++) begin : g_cell
    assign cell_en[j] = grant && legal && (win_flag == FW'(j));

    sr_flag_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (cell_en[j]),
      .s     (cell_s),
      .r     (cell_r),
      .q     (flags[j])
    );
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - self-checking bench for sr_flag_arbiter with a behavioural model
module tb_sr_flag_arbiter;

  localparam int N  = 4;
  localparam int NF = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [N-1:0]  req_valid;
  logic [2*N-1:0] req_op;
  logic [FW*N-1:0] req_flag;
  logic [N-1:0]  req_ready;
  logic [NF-1:0] flags;
  logic [2:0]    gnt_id;
  logic          err;
  logic [2:0]    err_id;

  logic [N-1:0]  v6;
  logic [2*N-1:0] op6;
  logic [FW*N-1:0] fl6;
  logic [N-1:0]  ready6;
  logic [5:0]    flags6;
  logic [2:0]    gnt6;
  logic          err6;
  logic [2:0]    eid6;

  int checks   = 0;
  int failures = 0;

  int          m_ptr;
  logic [NF-1:0] m_flags;
  int          m_gnt;
  logic        m_err;
  int          m_eid;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.N_REQ(N), .N_FLAGS(NF), .FW(FW)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_op(req_op),
    .req_flag(req_flag), .req_ready(req_ready), .flags(flags), .gnt_id(gnt_id),
    .err(err), .err_id(err_id)
  );

  sr_flag_arbiter #(.N_REQ(N), .N_FLAGS(6), .FW(3)) dut6 (
    .clk(clk), .reset(reset), .en(en), .req_valid(v6), .req_op(op6),
    .req_flag(fl6), .req_ready(ready6), .flags(flags6), .gnt_id(gnt6),
    .err(err6), .err_id(eid6)
  );

  task automatic m_reset();
    m_ptr = 0; m_flags = '0; m_gnt = 0; m_err = 1'b0; m_eid = 0;
  endtask

  function automatic int m_winner();
    if (!en) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w;
    logic [N-1:0] r;
    w = m_winner();
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    int w;
    logic [1:0] op;
    int fl;
    w = m_winner();
    @(posedge clk);
    if (w >= 0) begin
      op    = req_op[2*w +: 2];
      fl    = int'(req_flag[FW*w +: FW]);
      m_ptr = (w + 1) % N;
      m_gnt = w;
      if (op == 2'b11 || fl >= NF) begin
        m_err = 1'b1;
        m_eid = w;
      end else begin
        m_err = 1'b0;
        if (op == 2'b10) m_flags[fl] = 1'b1;
        else if (op == 2'b01) m_flags[fl] = 1'b0;
      end
    end else begin
      m_err = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input int fl);
    req_valid[i]          = v;
    req_op[2*i +: 2]      = op;
    req_flag[FW*i +: FW]  = FW'(fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    v6 = '0;
    #2;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    req_valid = '0; req_op = '0; req_flag = '0;
    v6 = '0; op6 = '0; fl6 = '0;
    en = 1'b0; reset = 1'b0;
    #2;
    reset = 1'b1;
    req_valid = 4'hF;
    en = 1'b1;
    #1;
    checks++;
    if (flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h exp=00", flags); end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    #9;
    reset = 1'b0;
    req_valid = '0;
    m_reset();
    #1;
    checks++;
    if (gnt_id !== 3'd0 || err_id !== 3'd0) begin
      failures++; $display("FAIL reset_ids gnt_id=%0d err_id=%0d exp=0,0", gnt_id, err_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    set_req(0, 1'b1, 2'b10, 3);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_set_ready got=%b exp=0001", req_ready); end
    step();
    checks++;
    if (flags !== 8'h08) begin failures++; $display("FAIL single_set_flags got=%h exp=08", flags); end
    @(negedge clk);
    set_req(0, 1'b1, 2'b01, 3);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_clr_ready got=%b exp=0001", req_ready); end
    step();
    checks++;
    if (flags !== 8'h00) begin failures++; $display("FAIL single_clr_flags got=%h exp=00", flags); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b10, i);
    for (int g = 0; g < N; g++) begin
      logic [N-1:0] exp;
      exp = '0;
      exp[g] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp) begin failures++; $display("FAIL rr_ready_%0d got=%b exp=%b", g, req_ready, exp); end
      step();
      checks++;
      if (gnt_id !== 3'(g)) begin failures++; $display("FAIL rr_gnt_id_%0d got=%0d exp=%0d", g, gnt_id, g); end
      if (g == N - 1) begin
        checks++;
        if (flags !== 8'h0F) begin failures++; $display("FAIL rr_flags got=%h exp=0F", flags); end
      end
      @(negedge clk);
      req_valid[g] = 1'b0;
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    set_req(0, 1'b1, 2'b00, 0);
    #1;
    step();
    @(negedge clk);
    req_valid = '0;
    set_req(1, 1'b1, 2'b10, 5);
    set_req(2, 1'b1, 2'b01, 5);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL conflict_first got=%b exp=0010", req_ready); end
    step();
    checks++;
    if (flags[5] !== 1'b1) begin failures++; $display("FAIL conflict_mid got=%b exp=1", flags[5]); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL conflict_second got=%b exp=0100", req_ready); end
    step();
    checks++;
    if (flags[5] !== 1'b0 || gnt_id !== 3'd2) begin
      failures++; $display("FAIL conflict_final flag5=%b gnt_id=%0d exp=0,2", flags[5], gnt_id);
    end
    req_valid = '0;
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    set_req(0, 1'b1, 2'b10, 2);
    #1;
    step();
    @(negedge clk);
    req_valid = '0;
    set_req(3, 1'b1, 2'b11, 2);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL illegal_ready got=%b exp=1000", req_ready); end
    step();
    checks++;
    if (err !== 1'b1 || err_id !== 3'd3) begin failures++; $display("FAIL illegal_err err=%b err_id=%0d exp=1,3", err, err_id); end
    checks++;
    if (flags !== 8'h04 || gnt_id !== 3'd3) begin
      failures++; $display("FAIL illegal_flags flags=%h gnt_id=%0d exp=04,3", flags, gnt_id);
    end
    @(negedge clk);
    req_valid = '0;
    set_req(0, 1'b1, 2'b00, 0);
    #1;
    step();
    checks++;
    if (err !== 1'b0 || flags !== 8'h04) begin failures++; $display("FAIL illegal_clear err=%b flags=%h exp=0,04", err, flags); end
    @(negedge clk);
    req_valid = '0;
    set_req(3, 1'b1, 2'b11, 5);
    #1;
    step();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL illegal_again err=%b exp=1", err); end
    @(negedge clk);
    req_valid = '0;
    #1;
    step();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL illegal_pulse err=%b exp=0", err); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    v6[1] = 1'b1; op6[3:2] = 2'b10; fl6[5:3] = 3'd5;
    #1;
    checks++;
    if (ready6 !== 4'b0010) begin failures++; $display("FAIL oor_ready got=%b exp=0010", ready6); end
    step();
    checks++;
    if (flags6 !== 6'h20 || err6 !== 1'b0) begin failures++; $display("FAIL oor_legal flags=%h err=%b exp=20,0", flags6, err6); end
    @(negedge clk);
    fl6[5:3] = 3'd6;
    #1;
    step();
    checks++;
    if (err6 !== 1'b1 || eid6 !== 3'd1 || flags6 !== 6'h20) begin
      failures++; $display("FAIL oor_6 err=%b err_id=%0d flags=%h exp=1,1,20", err6, eid6, flags6);
    end
    @(negedge clk);
    op6[3:2] = 2'b01; fl6[5:3] = 3'd7;
    #1;
    step();
    checks++;
    if (err6 !== 1'b1 || flags6 !== 6'h20 || gnt6 !== 3'd1) begin
      failures++; $display("FAIL oor_7 err=%b flags=%h gnt_id=%0d exp=1,20,1", err6, flags6, gnt6);
    end
    @(negedge clk);
    v6 = '0;
    #1;
    step();
    checks++;
    if (err6 !== 1'b0) begin failures++; $display("FAIL oor_pulse err=%b exp=0", err6); end
  endtask

  task automatic test_enable();
    do_reset();
    @(negedge clk);
    en = 1'b0;
    set_req(0, 1'b1, 2'b10, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL en_off_ready_%0d got=%b exp=0000", c, req_ready); end
      step();
      checks++;
      if (flags !== 8'h00) begin failures++; $display("FAIL en_off_flags_%0d got=%h exp=00", c, flags); end
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL en_on_ready got=%b exp=0001", req_ready); end
    step();
    checks++;
    if (flags !== 8'h02) begin failures++; $display("FAIL en_on_flags got=%h exp=02", flags); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    en = 1'b1;
    set_req(0, 1'b1, 2'b10, 0);
    #1;
    step();
    checks++;
    if (flags !== 8'h01) begin failures++; $display("FAIL mid_pre_flags got=%h exp=01", flags); end
    @(negedge clk);
    req_valid = '0;
    set_req(1, 1'b1, 2'b10, 1);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_ready got=%b exp=0010", req_ready); end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (flags !== 8'h00 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_async flags=%h ready=%b exp=00,0000", flags, req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (flags !== 8'h00) begin failures++; $display("FAIL mid_discard flags=%h exp=00", flags); end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    set_req(0, 1'b1, 2'b10, 3);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr ready=%b exp=0001", req_ready); end
    step();
    checks++;
    if (flags !== 8'h08 || gnt_id !== 3'd0) begin
      failures++; $display("FAIL mid_after flags=%h gnt_id=%0d exp=08,0", flags, gnt_id);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int waitc[N];
    do_reset();
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int w;
      logic [N-1:0] exp;
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom_range(0, NF - 1));
        end
      end
      #1;
      exp = m_ready();
      w = m_winner();
      checks++;
      if (req_ready !== exp) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp); end
      if (w >= 0) begin
        checks++;
        if (waitc[w] > N - 1) begin failures++; $display("FAIL rnd_fair cyc=%0d req=%0d waited=%0d max=%0d", cyc, w, waitc[w], N - 1); end
      end
      step();
      checks++;
      if (flags !== m_flags || gnt_id !== 3'(m_gnt) || err !== m_err) begin
        failures++;
        $display("FAIL rnd_state cyc=%0d flags=%h gnt_id=%0d err=%b exp=%h,%0d,%b", cyc, flags, gnt_id, err, m_flags, m_gnt, m_err);
      end
      if (m_err) begin
        checks++;
        if (err_id !== 3'(m_eid)) begin failures++; $display("FAIL rnd_err_id cyc=%0d got=%0d exp=%0d", cyc, err_id, m_eid); end
      end
      for (int i = 0; i < N; i++) begin
        if (i == w) begin
          req_valid[i] = 1'b0;
          waitc[i] = 0;
        end else if (req_valid[i] && en) begin
          waitc[i]++;
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_conflict();
    test_illegal();
    test_out_of_range();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
